// File: rtl/alu_seq_if.sv
// Control-unit / accumulator connection of the sequential ALU.
// The master drives the request and operands. The slave (the ALU) returns the
// result, the write strobe and the status flags.
interface alu_seq_if #(
  parameter int reg_width = 12
);
  logic                 start;
  logic [2:0]           op;
  logic [reg_width-1:0] ac_val;
  logic [reg_width-1:0] bus_val;
  logic [reg_width-1:0] result;
  logic                 ac_write_en;
  logic                 busy;
  logic                 done;
  logic                 z_flag;
  logic                 c_flag;

  modport master (
    output start, op, ac_val, bus_val,
    input  result, ac_write_en, busy, done, z_flag, c_flag
  );

  modport slave (
    input  start, op, ac_val, bus_val,
    output result, ac_write_en, busy, done, z_flag, c_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with a shift-add multiplier.
// Operands are latched on start. Single-cycle ops pass through EXEC.
// MUL runs reg_width shift-add steps and then uses one EXEC cycle to format
// the product. FIN is a one-cycle completion state that drives done and the
// accumulator write strobe. All outputs are registered.
module alu_seq #(
  parameter int reg_width = 12
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);
  localparam int W  = reg_width;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_mplier;
  logic [2*W-1:0]  r_mcand;
  logic [2*W-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;
  logic            r_we;
  logic            r_busy;
  logic            r_done;
  logic            r_z;
  logic            r_c;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_res;
  logic            w_carry;
  logic            w_mul_last;

  // The last multiplier bit is processed when the step counter reaches W-1.
  assign w_mul_last = (r_cnt == CW'(W - 1));

  // State register; reset forces IDLE and aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so nothing is queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.op == OP_MUL) ? MUL : EXEC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: w_state_nxt = FIN;
      MUL: begin
        if (w_mul_last) begin
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = MUL;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result and flag computation from the latched operands (or from the product for MUL).
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    case (r_op)
      OP_LOAD: w_res = r_b;
      OP_ADD: begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
      end
      OP_SUB: begin
        // The extra top bit of the difference is the borrow (set when ac < bus).
        w_sum   = {1'b0, r_a} - {1'b0, r_b};
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
      end
      OP_INC: begin
        w_sum   = {1'b0, r_a} + {{W{1'b0}}, 1'b1};
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
      end
      OP_MUL: begin
        w_res   = r_prod[W-1:0];
        w_carry = |r_prod[2*W-1:W];
      end
      OP_AND: w_res = r_a & r_b;
      OP_CLR: w_res = '0;
      OP_NOP: begin
        w_res   = r_result;
        w_carry = r_c;
      end
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  // Latch the operands on an accepted start, then run one shift-add step per MUL cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_a      <= bus.ac_val;
            r_b      <= bus.bus_val;
            r_mcand  <= {{W{1'b0}}, bus.ac_val};
            r_mplier <= bus.bus_val;
            r_prod   <= '0;
            r_cnt    <= '0;
          end
        end
        MUL: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs. Strobes are derived from the next state; result and flags are captured when leaving EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == EXEC) || (w_state_nxt == MUL);
      r_done <= (w_state_nxt == FIN);
      r_we   <= (w_state_nxt == FIN) && (r_op != OP_NOP);
      if ((r_state == EXEC) && (r_op != OP_NOP)) begin
        r_result <= w_res;
        r_z      <= (w_res == '0);
        r_c      <= w_carry;
      end
    end
  end

  assign bus.result      = r_result;
  assign bus.ac_write_en = r_we;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.z_flag      = r_z;
  assign bus.c_flag      = r_c;
endmodule
